// File: rtl/mem_vector_sequencer.sv
// Vector load/store sequencer: turns one start request into NUM_ELEM word
// accesses at base_addr+k and assembles or scatters a 16-element vector.
module mem_vector_sequencer #(
   parameter int NUM_ELEM = 16,
   parameter int ELEM_W   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             is_store,
   input  logic [15:0]                      base_addr,
   input  logic [4:0]                       RD_in,
   input  logic [NUM_ELEM-1:0][ELEM_W-1:0]  store_data,
   input  logic                             stall,
   input  logic [ELEM_W-1:0]                mem_rdata,
   output logic [15:0]                      mem_addr,
   output logic                             mem_re,
   output logic                             mem_we,
   output logic [ELEM_W-1:0]                mem_wdata,
   output logic                             busy,
   output logic                             done,
   output logic                             wb_en,
   output logic [4:0]                       RD_out,
   output logic [NUM_ELEM-1:0][ELEM_W-1:0]  load_data
);

   localparam int IDX_W = $clog2(NUM_ELEM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      STORE,
      DONE
   } state_t;

   state_t                            state;
   state_t                            state_next;
   logic [IDX_W-1:0]                  k;
   logic [15:0]                       base_q;
   logic [NUM_ELEM-1:0][ELEM_W-1:0]   store_q;
   logic                              is_store_q;
   logic                              rd_pending;
   logic [IDX_W-1:0]                  rd_idx;
   logic                              accept;

   assign accept = (state == IDLE) && start;

   // Strobes and the address/data buses are decoded straight from the state so
   // that an access appears in the same cycle the state is entered.
   always_comb begin
      state_next = state;
      mem_addr   = '0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      done       = 1'b0;
      wb_en      = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               state_next = is_store ? STORE : LOAD;
            end
         end
         LOAD: begin
            if (!stall) begin
               mem_re   = 1'b1;
               mem_addr = base_q + 16'(k);
               if (k == LAST_IDX) begin
                  state_next = DRAIN;
               end
            end
         end
         STORE: begin
            if (!stall) begin
               mem_we    = 1'b1;
               mem_addr  = base_q + 16'(k);
               mem_wdata = store_q[k];
               if (k == LAST_IDX) begin
                  state_next = DONE;
               end
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            wb_en      = !is_store_q;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         base_q     <= '0;
         store_q    <= '0;
         is_store_q <= 1'b0;
         RD_out     <= '0;
         rd_pending <= 1'b0;
         rd_idx     <= '0;
         load_data  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            k          <= '0;
            base_q     <= base_addr;
            store_q    <= store_data;
            is_store_q <= is_store;
            RD_out     <= RD_in;
         end else if (mem_re || mem_we) begin
            k <= k + 1'b1;
         end
         // Read data returns one cycle after the strobe, so capture is tracked
         // separately from issue and is unaffected by stall.
         rd_pending <= mem_re;
         rd_idx     <= k;
         if (rd_pending) begin
            load_data[rd_idx] <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_vector_sequencer.sv
// Scoreboard bench for mem_vector_sequencer: a transaction-level model predicts
// every memory access and completion; a negedge monitor compares.
module tb_mem_vector_sequencer;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                is_store;
   logic [15:0]         base_addr;
   logic [4:0]          RD_in;
   logic [15:0][15:0]   store_data;
   logic                stall;
   logic [15:0]         mem_rdata;
   logic [15:0]         mem_addr;
   logic                mem_re;
   logic                mem_we;
   logic [15:0]         mem_wdata;
   logic                busy;
   logic                done;
   logic                wb_en;
   logic [4:0]          RD_out;
   logic [15:0][15:0]   load_data;

   mem_vector_sequencer #(.NUM_ELEM(16), .ELEM_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_store   (is_store),
      .base_addr  (base_addr),
      .RD_in      (RD_in),
      .store_data (store_data),
      .stall      (stall),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .wb_en      (wb_en),
      .RD_out     (RD_out),
      .load_data  (load_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;
   int busy_start = -10;
   int busy_end   = -10;
   logic [15:0]  mem_key = 16'hA5A5;
   logic [255:0] last_load = '0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } acc_t;

   typedef struct {
      int           cyc;
      logic         wb;
      logic [4:0]   rd;
      logic [255:0] vec;
   } comp_t;

   acc_t  acc_q[$];
   comp_t comp_q[$];
   acc_t  ma;
   comp_t mc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Memory: answers a read one cycle later with addr ^ mem_key, junk otherwise.
   bit          rp;
   logic [15:0] ra;
   always @(negedge clk) begin
      rp = mem_re;
      ra = mem_addr;
   end
   always @(posedge clk) mem_rdata <= rp ? (ra ^ mem_key) : 16'($urandom);

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_re || mem_we) begin
            chk("strobe_excl", 256'(mem_re & mem_we), '0);
            if (acc_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL acc_extra: got access at addr %h, expected none (cycle %0d)", mem_addr, cyc);
            end else begin
               ma = acc_q.pop_front();
               chk("acc_cycle", 256'(cyc), 256'(ma.cyc));
               chk("acc_we", 256'(mem_we), 256'(ma.we));
               chk("acc_addr", 256'(mem_addr), 256'(ma.addr));
               chk("acc_wdata", 256'(mem_wdata), 256'(ma.wdata));
            end
         end else begin
            chk("addr_zero", 256'(mem_addr), '0);
            chk("wdata_zero", 256'(mem_wdata), '0);
            if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
               ma = acc_q.pop_front();
               total++;
               bad++;
               $display("FAIL acc_missing: got no strobe, expected addr %h at cycle %0d", ma.addr, ma.cyc);
            end
         end
         if (done) begin
            if (comp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_extra: got done, expected none (cycle %0d)", cyc);
            end else begin
               mc = comp_q.pop_front();
               chk("done_cycle", 256'(cyc), 256'(mc.cyc));
               chk("wb_en", 256'(wb_en), 256'(mc.wb));
               chk("rd_out", 256'(RD_out), 256'(mc.rd));
               chk("load_data", load_data, mc.vec);
            end
         end else begin
            chk("wb_without_done", 256'(wb_en), '0);
            if (comp_q.size() > 0 && comp_q[0].cyc <= cyc) begin
               mc = comp_q.pop_front();
               total++;
               bad++;
               $display("FAIL done_missing: got no done, expected at cycle %0d", mc.cyc);
            end
         end
         chk("busy", 256'(busy), 256'(cyc > busy_start && cyc <= busy_end));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         stall = 1'($urandom);
      end
   endtask

   // One transfer: the model lists the unstalled cycles as the issue slots for
   // elements 0..15 in order; completion follows the last slot (+1 for loads).
   task automatic run_txn(input bit st, input logic [15:0] base, input logic [4:0] rd,
                          input logic [255:0] sdata, input logic [63:0] smask,
                          input bit noisy, input int abort_at);
      int   t;
      int   n;
      int   c;
      int   dcyc;
      int   ncyc;
      acc_t e;
      comp_t d;
      logic [255:0] vec;
      @(posedge clk);
      #1;
      start      = 1'b1;
      is_store   = st;
      base_addr  = base;
      RD_in      = rd;
      store_data = sdata;
      stall      = 1'($urandom);
      t = cyc;
      n = 0;
      c = 1;
      while (n < 16) begin
         if (!smask[c]) begin
            e.cyc   = t + c;
            e.we    = st;
            e.addr  = base + 16'(n);
            e.wdata = st ? sdata[n*16 +: 16] : 16'h0;
            if (abort_at == 0 || c <= abort_at) acc_q.push_back(e);
            n++;
         end
         c++;
      end
      dcyc = st ? t + c : t + c + 1;
      busy_start = t;
      if (abort_at == 0) begin
         for (int k = 0; k < 16; k++) begin
            vec[k*16 +: 16] = st ? last_load[k*16 +: 16] : ((base + 16'(k)) ^ mem_key);
         end
         d.cyc = dcyc;
         d.wb  = !st;
         d.rd  = rd;
         d.vec = vec;
         comp_q.push_back(d);
         if (!st) last_load = vec;
         busy_end = dcyc;
         ncyc = dcyc - t;
      end else begin
         last_load = '0;
         busy_end  = t + abort_at;
         ncyc      = abort_at + 1;
      end
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk);
         #1;
         stall = smask[i];
         rst   = (abort_at != 0 && i == abort_at);
         if (noisy && !(abort_at != 0 && i >= abort_at)) begin
            start      = 1'($urandom);
            is_store   = 1'($urandom);
            base_addr  = 16'($urandom);
            RD_in      = 5'($urandom);
            store_data = rand256();
         end else begin
            start = 1'b0;
         end
         if (abort_at != 0 && i == abort_at + 1) begin
            chk("abort_busy", 256'(busy), '0);
            chk("abort_done", 256'(done), '0);
            chk("abort_wb", 256'(wb_en), '0);
            chk("abort_re", 256'(mem_re), '0);
            chk("abort_we", 256'(mem_we), '0);
            chk("abort_addr", 256'(mem_addr), '0);
            chk("abort_wdata", 256'(mem_wdata), '0);
            chk("abort_rd_out", 256'(RD_out), '0);
            chk("abort_load_data", load_data, '0);
         end
      end
   endtask

   logic [255:0] sd;
   logic [63:0]  m;
   logic [15:0]  b;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      is_store   = 1'b0;
      base_addr  = '0;
      RD_in      = '0;
      store_data = '0;
      stall      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 256'(busy), '0);
      chk("rst_done", 256'(done), '0);
      chk("rst_wb", 256'(wb_en), '0);
      chk("rst_re_we", 256'({mem_re, mem_we}), '0);
      chk("rst_addr", 256'(mem_addr), '0);
      chk("rst_wdata", 256'(mem_wdata), '0);
      chk("rst_rd_out", 256'(RD_out), '0);
      chk("rst_load_data", load_data, '0);
      rst    = 1'b0;
      mon_en = 1'b1;

      mem_key = 16'hA5A5;
      run_txn(1'b0, 16'h0100, 5'd5, '0, '0, 1'b0, 0);
      idle(2);
      for (int k = 0; k < 16; k++) sd[k*16 +: 16] = 16'(k * 3);
      run_txn(1'b1, 16'h0020, 5'd11, sd, '0, 1'b0, 0);
      idle(1);
      run_txn(1'b0, 16'hFFFA, 5'd9, '0, '0, 1'b0, 0);
      run_txn(1'b0, 16'h3000, 5'd2, '0, 64'h1C0, 1'b0, 0);
      idle(2);
      run_txn(1'b0, 16'h0400, 5'd7, '0, '0, 1'b1, 8);
      idle(3);

      for (int j = 0; j < 30; j++) begin
         mem_key = 16'($urandom);
         m = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFE;
         if ($urandom_range(0, 2) == 0) m = '0;
         b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
         run_txn(1'($urandom), b, 5'($urandom), rand256(), m, 1'($urandom), 0);
         idle($urandom_range(0, 3));
      end

      idle(4);
      chk("acc_queue_empty", 256'(acc_q.size()), '0);
      chk("comp_queue_empty", 256'(comp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
